// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the back half of the pipeline: control-bundle widths and
// the EXE/MEM and MEM/WB register layouts.
package mem_wb_stage_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef logic [REG_W-1:0]  reg_num_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic     wreg;
        logic     m2reg;
        logic     wmem;
        reg_num_t d;
        data_t    alu;
        data_t    b;
    } exe_mem_t;

    typedef struct packed {
        logic     wreg;
        logic     m2reg;
        reg_num_t d;
        data_t    alu;
        data_t    mdata;
    } mem_wb_t;

    // r0 is hardwired to zero, so a write aimed at it is dropped.
    function automatic logic wreg_gate(input logic wreg, input reg_num_t d);
        return wreg && (d != '0);
    endfunction

endpackage

// File: rtl/mem_wb_stage_dmem.sv
// Word-addressed data memory: synchronous write port, asynchronous read port
// sharing one address so a load sees the contents before the closing edge.
module dmem
    import mem_wb_stage_pkg::*;
#(
    parameter int DMEM_WORDS = 64,
    parameter int AW         = $clog2(DMEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  data_t         wdata,
    output data_t         rdata
);

    data_t ram [DMEM_WORDS];

    // NOTE: the array has no reset; contents survive pipeline reset and are
    // undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            ram[addr] <= wdata;
        end
    end

    assign rdata = ram[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM and WB stages: EXE/MEM and MEM/WB registers, data-memory access,
// write-back mux and a sticky misalignment flag.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DMEM_WORDS = 64,
    parameter int AW         = $clog2(DMEM_WORDS)
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        exe_wreg,
    input  logic        exe_m2reg,
    input  logic        exe_wmem,
    input  logic [4:0]  exe_d,
    input  logic [31:0] exe_alu,
    input  logic [31:0] exe_b,
    output logic        mem_wreg,
    output logic [4:0]  mem_d,
    output logic [31:0] mem_alu,
    output logic        wb_wreg,
    output logic [4:0]  wb_d,
    output logic [31:0] wdi,
    output logic        misalign
);

    exe_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t  mem_wb_d, mem_wb_q;
    logic     misalign_d, misalign_q;
    data_t    mem_rdata;
    logic     mem_access;

    dmem #(
        .DMEM_WORDS (DMEM_WORDS),
        .AW         (AW)
    ) u_dmem (
        .clk   (clk),
        .we    (ex_mem_q.wmem),
        .addr  (ex_mem_q.alu[AW+1:2]),
        .wdata (ex_mem_q.b),
        .rdata (mem_rdata)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        ex_mem_d       = '0;
        ex_mem_d.wreg  = wreg_gate(exe_wreg, exe_d);
        ex_mem_d.m2reg = exe_m2reg;
        ex_mem_d.wmem  = exe_wmem;
        ex_mem_d.d     = exe_d;
        ex_mem_d.alu   = exe_alu;
        ex_mem_d.b     = exe_b;

        mem_wb_d       = '0;
        mem_wb_d.wreg  = wreg_gate(ex_mem_q.wreg, ex_mem_q.d);
        mem_wb_d.m2reg = ex_mem_q.m2reg;
        mem_wb_d.d     = ex_mem_q.d;
        mem_wb_d.alu   = ex_mem_q.alu;
        mem_wb_d.mdata = mem_rdata;

        // The access still proceeds at the truncated word address.
        mem_access = ex_mem_q.wmem | ex_mem_q.m2reg;
        misalign_d = misalign_q | (mem_access & (ex_mem_q.alu[1:0] != 2'b00));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            ex_mem_q   <= '0;
            mem_wb_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            ex_mem_q   <= ex_mem_d;
            mem_wb_q   <= mem_wb_d;
            misalign_q <= misalign_d;
        end
    end

    assign mem_wreg = ex_mem_q.wreg;
    assign mem_d    = ex_mem_q.d;
    assign mem_alu  = ex_mem_q.alu;
    assign wb_wreg  = mem_wb_q.wreg;
    assign wb_d     = mem_wb_q.d;
    assign wdi      = mem_wb_q.m2reg ? mem_wb_q.mdata : mem_wb_q.alu;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected write-back triples are pushed
// when an instruction is driven and popped two edges later.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        clrn;
    logic        exe_wreg, exe_m2reg, exe_wmem;
    logic [4:0]  exe_d;
    logic [31:0] exe_alu, exe_b;
    logic        mem_wreg;
    logic [4:0]  mem_d;
    logic [31:0] mem_alu;
    logic        wb_wreg;
    logic [4:0]  wb_d;
    logic [31:0] wdi;
    logic        misalign;

    typedef struct {
        logic        wreg, m2reg, wmem;
        logic [4:0]  d;
        logic [31:0] alu, b;
    } inst_t;

    typedef struct {
        int          due;
        logic        wreg;
        logic [4:0]  d;
        logic [31:0] wdi;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl_mem [64];
    bit          mdl_valid [64];
    logic        mdl_mis;
    int          cyc;
    int          checks;
    int          errors;

    mem_wb_stage dut (
        .clk       (clk),
        .clrn      (clrn),
        .exe_wreg  (exe_wreg),
        .exe_m2reg (exe_m2reg),
        .exe_wmem  (exe_wmem),
        .exe_d     (exe_d),
        .exe_alu   (exe_alu),
        .exe_b     (exe_b),
        .mem_wreg  (mem_wreg),
        .mem_d     (mem_d),
        .mem_alu   (mem_alu),
        .wb_wreg   (wb_wreg),
        .wb_d      (wb_d),
        .wdi       (wdi),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    function automatic inst_t mk(input logic wreg, input logic m2reg, input logic wmem,
                                 input logic [4:0] d, input logic [31:0] alu, input logic [31:0] b);
        inst_t r;
        r.wreg = wreg; r.m2reg = m2reg; r.wmem = wmem; r.d = d; r.alu = alu; r.b = b;
        return r;
    endfunction

    task automatic drive(input inst_t in, input bit track);
        logic [5:0]  w;
        logic [31:0] ld;
        exp_t        e;
        exe_wreg  = in.wreg;
        exe_m2reg = in.m2reg;
        exe_wmem  = in.wmem;
        exe_d     = in.d;
        exe_alu   = in.alu;
        exe_b     = in.b;
        if (track) begin
            w  = in.alu[7:2];
            ld = mdl_mem[w];
            if ((in.wmem || in.m2reg) && in.alu[1:0] != 2'b00) mdl_mis = 1'b1;
            e.due  = cyc + 2;
            e.wreg = in.wreg && (in.d != 5'd0);
            e.d    = in.d;
            e.wdi  = in.m2reg ? ld : in.alu;
            e.mis  = mdl_mis;
            sb.push_back(e);
            if (in.wmem) begin
                mdl_mem[w]   = in.b;
                mdl_valid[w] = 1'b1;
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        clrn = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0), 1'b0);
        repeat (2) tick();
        clrn = 1'b0;
        drive(mk(1, 0, 0, 9, 32'h55, 0), 1'b0);
        tick();
        drive(mk(1, 0, 0, 10, 32'h66, 0), 1'b0);
        tick();
        #3 clrn = 1'b1;
        #1;
        checks++;
        if (mem_wreg !== 1'b0 || mem_d !== 5'd0 || mem_alu !== 32'd0) begin
            errors++;
            $display("FAIL reset_mem: got wreg=%0b d=%0d alu=%h, want all 0", mem_wreg, mem_d, mem_alu);
        end
        checks++;
        if (wb_wreg !== 1'b0 || wb_d !== 5'd0 || wdi !== 32'd0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_wb: got wreg=%0b d=%0d wdi=%h mis=%0b, want all 0", wb_wreg, wb_d, wdi, misalign);
        end
        drive(mk(0, 0, 0, 0, 0, 0), 1'b0);
        tick();
        clrn = 1'b0;
        sb.delete();
        mdl_mis = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (wb_wreg !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: got wb_wreg=%0b, want 0", wb_wreg);
            end
        end
    endtask

    task automatic test_alu_wb;
        exp_t e;
        drive(mk(1, 0, 0, 5, 32'h0000_1234, 32'h0), 1'b1);
        tick();
        checks++;
        if (mem_wreg !== 1'b1 || mem_d !== 5'd5 || mem_alu !== 32'h1234) begin
            errors++;
            $display("FAIL alu_mem: got wreg=%0b d=%0d alu=%h, want 1 5 00001234", mem_wreg, mem_d, mem_alu);
        end
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0), 1'b1);
            tick();
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (wb_wreg !== e.wreg || (e.wreg && (wb_d !== e.d || wdi !== e.wdi)) || misalign !== e.mis) begin
                    errors++;
                    $display("FAIL alu_wb: got wreg=%0b d=%0d wdi=%h mis=%0b, want wreg=%0b d=%0d wdi=%h mis=%0b",
                             wb_wreg, wb_d, wdi, misalign, e.wreg, e.d, e.wdi, e.mis);
                end
            end
        end
    endtask

    task automatic test_store_load;
        inst_t prog[$];
        exp_t  e;
        prog.push_back(mk(0, 0, 1, 0, 32'h10, 32'hDEAD_BEEF));
        prog.push_back(mk(1, 1, 0, 7, 32'h10, 32'h0));
        prog.push_back(mk(0, 0, 1, 0, 32'h110, 32'h0BAD_F00D));
        prog.push_back(mk(1, 1, 0, 9, 32'h10, 32'h0));
        prog.push_back(mk(1, 1, 1, 11, 32'h10, 32'h1234_5678));
        prog.push_back(mk(1, 1, 0, 12, 32'h10, 32'h0));
        prog.push_back(mk(0, 0, 0, 0, 0, 0));
        prog.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < prog.size(); i++) begin
            drive(prog[i], 1'b1);
            tick();
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (wb_wreg !== e.wreg || (e.wreg && (wb_d !== e.d || wdi !== e.wdi)) || misalign !== e.mis) begin
                    errors++;
                    $display("FAIL store_load: got wreg=%0b d=%0d wdi=%h mis=%0b, want wreg=%0b d=%0d wdi=%h mis=%0b",
                             wb_wreg, wb_d, wdi, misalign, e.wreg, e.d, e.wdi, e.mis);
                end
            end
        end
    endtask

    task automatic test_r0;
        exp_t e;
        drive(mk(1, 0, 0, 0, 32'hFFFF_FFFF, 32'h0), 1'b1);
        tick();
        checks++;
        if (mem_wreg !== 1'b0) begin
            errors++;
            $display("FAIL r0_mem: got mem_wreg=%0b, want 0", mem_wreg);
        end
        for (int i = 0; i < 2; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0), 1'b1);
            tick();
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (wb_wreg !== e.wreg || (e.wreg && (wb_d !== e.d || wdi !== e.wdi)) || misalign !== e.mis) begin
                    errors++;
                    $display("FAIL r0_wb: got wreg=%0b d=%0d wdi=%h, want wreg=%0b d=%0d wdi=%h",
                             wb_wreg, wb_d, wdi, e.wreg, e.d, e.wdi);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        inst_t in;
        exp_t  e;
        int    w;
        int    kind;
        for (int i = 0; i < 34; i++) begin
            w    = $urandom_range(0, 63);
            kind = (i >= 32) ? 3 : $urandom_range(0, 2);
            if (kind == 2 && !mdl_valid[w]) kind = 1;
            case (kind)
                0: in = mk(1, 0, 0, 5'($urandom_range(0, 31)), $urandom(), 32'h0);
                1: in = mk(0, 0, 1, 0, ($urandom() & 32'hFFFF_FF00) | (32'(w) << 2), $urandom());
                2: in = mk(1, 1, 0, 5'($urandom_range(0, 31)), ($urandom() & 32'hFFFF_FF00) | (32'(w) << 2), 32'h0);
                default: in = mk(0, 0, 0, 0, 0, 0);
            endcase
            drive(in, 1'b1);
            tick();
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (wb_wreg !== e.wreg || (e.wreg && (wb_d !== e.d || wdi !== e.wdi)) || misalign !== e.mis) begin
                    errors++;
                    $display("FAIL back_to_back: got wreg=%0b d=%0d wdi=%h mis=%0b, want wreg=%0b d=%0d wdi=%h mis=%0b",
                             wb_wreg, wb_d, wdi, misalign, e.wreg, e.d, e.wdi, e.mis);
                end
            end
        end
    endtask

    task automatic test_misalign;
        inst_t prog[$];
        exp_t  e;
        prog.push_back(mk(1, 0, 0, 6, 32'h3, 32'h0));
        prog.push_back(mk(0, 0, 1, 0, 32'h10, 32'hA5A5_A5A5));
        prog.push_back(mk(1, 1, 0, 4, 32'h13, 32'h0));
        prog.push_back(mk(0, 0, 1, 0, 32'h24, 32'h0F0F_0F0F));
        prog.push_back(mk(1, 1, 0, 13, 32'h24, 32'h0));
        prog.push_back(mk(0, 0, 0, 0, 0, 0));
        prog.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < prog.size(); i++) begin
            drive(prog[i], 1'b1);
            tick();
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (wb_wreg !== e.wreg || (e.wreg && (wb_d !== e.d || wdi !== e.wdi)) || misalign !== e.mis) begin
                    errors++;
                    $display("FAIL misalign: got wreg=%0b d=%0d wdi=%h mis=%0b, want wreg=%0b d=%0d wdi=%h mis=%0b",
                             wb_wreg, wb_d, wdi, misalign, e.wreg, e.d, e.wdi, e.mis);
                end
            end
        end
    endtask

    task automatic test_reset_during_store;
        inst_t prog[$];
        exp_t  e;
        drive(mk(0, 0, 1, 0, 32'h20, 32'h1111_1111), 1'b1);
        tick();
        drive(mk(0, 0, 0, 0, 0, 0), 1'b1);
        tick();
        drive(mk(0, 0, 1, 0, 32'h20, 32'h2222_2222), 1'b0);
        tick();
        drive(mk(1, 0, 0, 3, 32'h77, 32'h0), 1'b0);
        #3 clrn = 1'b1;
        #1;
        checks++;
        if (mem_wreg !== 1'b0 || wb_wreg !== 1'b0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL rst_store_now: got mem_wreg=%0b wb_wreg=%0b mis=%0b, want 0 0 0", mem_wreg, wb_wreg, misalign);
        end
        tick();
        drive(mk(0, 0, 0, 0, 0, 0), 1'b0);
        clrn = 1'b0;
        sb.delete();
        mdl_mis = 1'b0;
        prog.push_back(mk(1, 1, 0, 8, 32'h20, 32'h0));
        prog.push_back(mk(0, 0, 0, 0, 0, 0));
        prog.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < prog.size(); i++) begin
            checks++;
            if (wb_wreg !== 1'b0 && i < 2) begin
                errors++;
                $display("FAIL rst_store_nowb: got wb_wreg=%0b at step %0d, want 0", wb_wreg, i);
            end
            drive(prog[i], 1'b1);
            tick();
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (wb_wreg !== e.wreg || (e.wreg && (wb_d !== e.d || wdi !== e.wdi)) || misalign !== e.mis) begin
                    errors++;
                    $display("FAIL rst_store_load: got wreg=%0b d=%0d wdi=%h mis=%0b, want wreg=%0b d=%0d wdi=%h mis=%0b",
                             wb_wreg, wb_d, wdi, misalign, e.wreg, e.d, e.wdi, e.mis);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        mdl_mis = 1'b0;
        for (int i = 0; i < 64; i++) mdl_valid[i] = 1'b0;
        test_reset();
        test_alu_wb();
        test_store_load();
        test_r0();
        test_back_to_back();
        test_misalign();
        test_reset_during_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Back half of the five-stage pipeline: takes the control bundle and ALU result leaving EXE, performs the data-memory access in MEM, and produces the write-back triple `wb_d` / `wb_wreg` / `wdi` that the decode stage's register file consumes. It holds the EXE/MEM and MEM/WB pipeline registers, a word-addressed data memory, and a sticky misalignment flag.

## Interface
Parameters:
- `DMEM_WORDS`, 64: data memory depth in 32-bit words; power of two.
- `AW`, log2(`DMEM_WORDS`) = 6: word-address width.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `clrn`  in  1  asynchronous, active-high reset.
- `exe_wreg`  in  1  instruction in EXE writes a register.
- `exe_m2reg`  in  1  write-back value comes from memory (load).
- `exe_wmem`  in  1  instruction stores to memory.
- `exe_d`  in  5  destination register number.
- `exe_alu`  in  32  ALU result; byte address for loads and stores.
- `exe_b`  in  32  store data (register operand b).
- `mem_wreg`  out  1  MEM-stage write flag, for forwarding.
- `mem_d`  out  5  MEM-stage destination, for forwarding.
- `mem_alu`  out  32  MEM-stage ALU result, for forwarding.
- `wb_wreg`  out  1  register-file write enable.
- `wb_d`  out  5  register-file write address.
- `wdi`  out  32  register-file write data.
- `misalign`  out  1  sticky: an access had a nonzero `alu[1:0]`.

## Operation
- EXE/MEM register captures `exe_*` into `mem_wreg`, `mem_m2reg`, `mem_wmem`, `mem_d`, `mem_alu`, `mem_b` on every edge. There is no stall and no flush.
- Write suppression: a captured `wreg` is forced to 0 whenever its destination is 0, at both the MEM and WB registers. r0 is never written.
- Word address is `mem_alu[AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo `DMEM_WORDS`.
- Store: on the edge that ends the MEM cycle, if `mem_wmem`=1, the memory word at the word address is written with `mem_b`.
- Load: the memory read is combinational from the word address during the MEM cycle. The read sees contents before that cycle's closing write edge.
- MEM/WB register captures `wb_wreg`, `wb_d`, `wb_alu` and `wb_mdata` (the read data) on every edge, plus `wb_m2reg`.
- `wdi` = `wb_m2reg` ? `wb_mdata` : `wb_alu`. This mux is combinational.
- `misalign` is set on the edge that ends the MEM cycle when (`mem_wmem` | `mem_m2reg`) and `mem_alu[1:0]`≠0. It is cleared only by reset. The access still proceeds at the truncated word address.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset (`clrn`=1, takes effect immediately): all pipeline-register fields are 0, and `misalign`=0. The memory array is not cleared.
- Outputs during reset: `mem_wreg`=0, `mem_d`=0, `mem_alu`=0, `wb_wreg`=0, `wb_d`=0, `wdi`=0.
- Latency: an instruction presented on `exe_*` before edge N is in MEM after edge N. Its store commits at edge N+1, and its write-back triple is valid after edge N+1.
- The register file writes on the falling edge inside the WB cycle. `wdi` must therefore be stable from shortly after the rising edge.
- Store at edge K followed by a load to the same word in the next MEM cycle: the load returns the new data.
- A store and a load cannot occupy MEM at the same time. If `mem_wmem` and `mem_m2reg` are both 1, the load returns the old word and the store still commits.
- Reset asserted mid-operation:
  - In-flight instructions are discarded, and no write-back is produced for them.
  - A store in MEM at reset assertion does not commit.
  - Stores already committed remain in memory.

## Structure
- The shared pipeline package holds the control-bundle field widths: register number 5, data 32.
- One sub-module, `dmem`, is natural: it contains the `DMEM_WORDS`×32 array, the synchronous write port and the asynchronous read port.
- The pipeline registers, suppression logic, write-back mux and `misalign` flag live in `mem_wb_stage`.

## Test plan
- Reset then idle: assert `clrn` mid-cycle → all outputs 0 immediately. After release with all `exe_*`=0 → `wb_wreg` stays 0.
- ALU write-back: `exe_wreg`=1, `exe_d`=5, `exe_alu`=0x0000_1234 → two edges later `wb_wreg`=1, `wb_d`=5, `wdi`=0x1234. After one edge `mem_d`=5, `mem_alu`=0x1234.
- Store then load: store `exe_alu`=0x10, `exe_b`=0xDEADBEEF, then next cycle load `exe_d`=7 from 0x10 → `wdi`=0xDEADBEEF, `wb_d`=7. Addresses 0x110 and 0x10 alias with `AW`=6.
- r0 suppression: `exe_wreg`=1, `exe_d`=0, `exe_alu`=0xFFFF_FFFF → `wb_wreg`=0 at both stages.
- Misaligned access: load from 0x13 after storing 0xA5A5A5A5 at 0x10 → `wdi`=0xA5A5A5A5 and `misalign`=1. `misalign` stays 1 across later aligned accesses until reset.
- Reset during a store: store to 0x20 while in MEM, then assert `clrn` before the edge → a later load of 0x20 returns the prior value, and no write-back occurs.
